// File: rtl/wb_scratchpad_slave.sv
// Wishbone B3 scratchpad slave: DEPTH x 32-bit byte-writable storage with
// optional wait states, classic and incrementing-burst cycles, address errors.
module wb_scratchpad_slave #(
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_ni,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_we_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic [2:0]  wb_cti_i,
   input  logic [1:0]  wb_bte_i,
   output logic        wb_ack_o,
   output logic        wb_err_o,
   output logic        wb_rty_o,
   output logic [31:0] wb_dat_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = 3;
   localparam logic [2:0]  CTI_INCR = 3'b010;

   typedef enum logic [1:0] {IDLE, WAIT, ACK, BURST} state_t;

   state_t          state;
   logic [29:0]     waddr;
   logic [CW-1:0]   wait_cnt;
   logic            we_q;
   logic            misalign_q;
   logic [2:0]      cti_q;
   logic [1:0]      bte_q;

   logic [31:0]     mem [DEPTH];
   logic [31:0]     rd_q;

   logic            req_c;
   logic            term_c;
   logic            bad_c;
   logic            ack_c;
   logic            err_c;
   logic            we_c;
   logic            wr_c;
   logic [29:0]     inc_c;
   logic [29:0]     wrap_mask_c;
   logic [29:0]     adv_c;
   logic [AW-1:0]   rd_idx_c;

   // Termination decode; waddr keeps the full word address so a burst that
   // walks past the top of storage is seen as out of range rather than aliasing.
   always_comb begin
      req_c       = wb_rst_ni & wb_cyc_i & wb_stb_i;
      term_c      = req_c && (state == ACK || state == BURST);
      bad_c       = misalign_q || (waddr[29:AW] != '0);
      ack_c       = term_c && !bad_c;
      err_c       = term_c && bad_c;
      we_c        = (state == BURST) ? wb_we_i : we_q;
      wr_c        = ack_c && we_c;
      inc_c       = waddr + 30'd1;
      wrap_mask_c = '0;
      case (bte_q)
         2'b01:   wrap_mask_c = 30'd3;
         2'b10:   wrap_mask_c = 30'd7;
         2'b11:   wrap_mask_c = 30'd15;
         default: wrap_mask_c = '0;
      endcase
      adv_c = (bte_q == 2'b00) ? inc_c : ((waddr & ~wrap_mask_c) | (inc_c & wrap_mask_c));
      // Prefetch the word the next cycle will present, so read data is registered.
      if (state == IDLE) begin
         rd_idx_c = wb_adr_i[AW+1:2];
      end else if (ack_c) begin
         rd_idx_c = adv_c[AW-1:0];
      end else begin
         rd_idx_c = waddr[AW-1:0];
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         state      <= IDLE;
         waddr      <= '0;
         wait_cnt   <= '0;
         we_q       <= 1'b0;
         misalign_q <= 1'b0;
         cti_q      <= '0;
         bte_q      <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req_c) begin
                  waddr      <= wb_adr_i[31:2];
                  we_q       <= wb_we_i;
                  cti_q      <= wb_cti_i;
                  bte_q      <= wb_bte_i;
                  misalign_q <= (wb_adr_i[1:0] != 2'b00);
                  wait_cnt   <= '0;
                  state      <= (WAIT_STATES > 0) ? WAIT : ACK;
               end
            end
            WAIT: begin
               if (!req_c) begin
                  state <= IDLE;
               end else if (wait_cnt == CW'(WAIT_STATES - 1)) begin
                  wait_cnt <= '0;
                  state    <= ACK;
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
            end
            ACK: begin
               if (!wb_cyc_i) begin
                  state <= IDLE;
               end else if (term_c) begin
                  if (ack_c && cti_q == CTI_INCR) begin
                     state <= BURST;
                     waddr <= adv_c;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            BURST: begin
               if (!wb_cyc_i) begin
                  state <= IDLE;
               end else if (term_c) begin
                  if (err_c || wb_cti_i != CTI_INCR) state <= IDLE;
                  if (ack_c) waddr <= adv_c;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Storage is deliberately not reset; only acked, in-range writes land.
   always_ff @(posedge wb_clk_i) begin
      if (wr_c) begin
         for (int i = 0; i < 4; i++) begin
            if (wb_sel_i[i]) mem[waddr[AW-1:0]][8*i +: 8] <= wb_dat_i[8*i +: 8];
         end
      end
      rd_q <= mem[rd_idx_c];
   end

   assign wb_ack_o = ack_c;
   assign wb_err_o = err_c;
   assign wb_rty_o = 1'b0;
   assign wb_dat_o = ack_c ? rd_q : '0;

endmodule

// File: tb/tb_wb_scratchpad_slave.sv
// Randomized scoreboard bench for wb_scratchpad_slave: one instance with no wait
// states and one with three, both checked against a word-array reference model.
module tb_wb_scratchpad_slave;

   localparam int unsigned DEPTH = 256;

   typedef struct {
      logic        err;
      logic        rd;
      logic        chk;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cyc [2];
   logic        stb [2];
   logic        we [2];
   logic [31:0] adr [2];
   logic [31:0] dat_w [2];
   logic [3:0]  sel [2];
   logic [2:0]  cti [2];
   logic [1:0]  bte [2];
   logic        ack [2];
   logic        err [2];
   logic        rty [2];
   logic [31:0] dat_r [2];

   int          total = 0;
   int          bad = 0;
   logic [31:0] ref_mem [2][DEPTH];
   bit          known [2][DEPTH];
   exp_t        q0[$];
   exp_t        q1[$];

   wb_scratchpad_slave #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
      .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_adr_i(adr[0]), .wb_dat_i(dat_w[0]),
      .wb_sel_i(sel[0]), .wb_we_i(we[0]), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]),
      .wb_cti_i(cti[0]), .wb_bte_i(bte[0]), .wb_ack_o(ack[0]), .wb_err_o(err[0]),
      .wb_rty_o(rty[0]), .wb_dat_o(dat_r[0])
   );

   wb_scratchpad_slave #(.DEPTH(DEPTH), .WAIT_STATES(3)) u_dut1 (
      .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_adr_i(adr[1]), .wb_dat_i(dat_w[1]),
      .wb_sel_i(sel[1]), .wb_we_i(we[1]), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]),
      .wb_cti_i(cti[1]), .wb_bte_i(bte[1]), .wb_ack_o(ack[1]), .wb_err_o(err[1]),
      .wb_rty_o(rty[1]), .wb_dat_o(dat_r[1])
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s dut%0d: got %h want %h at %0t", name, d, act, want, $time);
      end
   endtask

   function automatic int ws_of(input int d);
      return (d == 0) ? 0 : 3;
   endfunction

   task automatic push_exp(input int d, input exp_t e);
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
   endtask

   task automatic idle_bus(input int d);
      cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0; adr[d] = '0;
      dat_w[d] = '0; sel[d] = '0; cti[d] = '0; bte[d] = '0;
   endtask

   task automatic model_write(input int d, input int w, input logic [31:0] data, input logic [3:0] s);
      for (int i = 0; i < 4; i++) begin
         if (s[i]) ref_mem[d][w][8*i +: 8] = data[8*i +: 8];
      end
      if (s == 4'hF) known[d][w] = 1'b1;
   endtask

   // Cycles from driving a request until a termination is visible (bounded).
   task automatic wait_term(input int d, output int n);
      n = 0;
      @(negedge clk);
      while (!(ack[d] || err[d]) && n < 20) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
   endtask

   task automatic classic(input int d, input logic w, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] s);
      exp_t e;
      int   word;
      int   n;
      word  = int'(a >> 2);
      e.err = (a[1:0] != 2'b00) || (word >= int'(DEPTH));
      e.rd  = !w;
      e.chk = !w && !e.err && known[d][word];
      e.data = e.err ? 32'h0 : ref_mem[d][word];
      push_exp(d, e);
      if (w && !e.err) model_write(d, word, wd, s);
      cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a;
      dat_w[d] = wd; sel[d] = s; cti[d] = 3'b000; bte[d] = 2'b00;
      wait_term(d, n);
      check("classic_latency", d, 32'(n), 32'(1 + ws_of(d)));
      @(posedge clk);
      #1;
      idle_bus(d);
      @(negedge clk);
      check("term_one_cycle", d, 32'(ack[d] | err[d]), 32'h0);
      @(posedge clk);
      #1;
   endtask

   // Burst of nb beats; last beat carries cti=111. The bus is left driven so a
   // following request can be issued back-to-back.
   task automatic burst(input int d, input logic w_mode, input logic mix_we, input logic [31:0] a,
                        input int nb, input logic [1:0] b, input logic [31:0] base,
                        input logic rnd, input int pause_k, input int rst_k);
      exp_t        e;
      int          word0;
      int          wk;
      int          nwrap;
      int          n;
      logic        w;
      logic [31:0] wd;
      logic [3:0]  s;
      word0 = int'(a >> 2);
      nwrap = (b == 2'b01) ? 4 : (b == 2'b10) ? 8 : (b == 2'b11) ? 16 : 0;
      for (int k = 0; k < nb; k++) begin
         if (k == pause_k) begin
            stb[d] = 1'b0;
            @(posedge clk);
            @(posedge clk);
            #1;
         end
         wk = (nwrap == 0) ? word0 + k : (word0 - (word0 % nwrap)) + ((word0 + k) % nwrap);
         w  = mix_we ? 1'($urandom_range(0, 1)) : w_mode;
         wd = rnd ? $urandom : base + 32'(k);
         s  = rnd ? 4'($urandom_range(0, 15)) : 4'hF;
         cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = 32'(wk) * 4;
         dat_w[d] = wd; sel[d] = s; bte[d] = b;
         cti[d] = (k == nb - 1) ? 3'b111 : 3'b010;
         if (k == rst_k) begin
            rst_n = 1'b0;
            @(negedge clk);
            check("reset_cycle_no_term", d, 32'(ack[d] | err[d]), 32'h0);
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            idle_bus(d);
            @(negedge clk);
            check("after_reset_no_term", d, 32'(ack[d] | err[d]), 32'h0);
            @(posedge clk);
            #1;
            return;
         end
         e.err  = (wk >= int'(DEPTH));
         e.rd   = !w;
         e.chk  = !w && !e.err && known[d][wk];
         e.data = e.err ? 32'h0 : ref_mem[d][wk];
         push_exp(d, e);
         if (w && !e.err) model_write(d, wk, wd, s);
         wait_term(d, n);
         check("beat_latency", d, 32'(n), 32'((k == 0) ? 1 + ws_of(d) : 0));
         @(posedge clk);
         #1;
         if (e.err) break;
      end
   endtask

   // Scoreboard monitor: every termination must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      logic have;
      for (int d = 0; d < 2; d++) begin
         check("ack_err_exclusive", d, 32'(ack[d] & err[d]), 32'h0);
         if (!ack[d]) check("dat_zero_without_ack", d, dat_r[d], 32'h0);
         if (ack[d] || err[d]) begin
            have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
            if (!have) begin
               check("unexpected_term", d, {30'h0, ack[d], err[d]}, 32'h0);
            end else begin
               if (d == 0) e = q0.pop_front();
               else e = q1.pop_front();
               check("term_kind_err", d, 32'(err[d]), 32'(e.err));
               if (e.rd && e.chk && !e.err) check("read_data", d, dat_r[d], e.data);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      int          word;
      int          nb;
      int          pk;
      logic [31:0] a;
      rst_n = 1'b0;
      idle_bus(0);
      idle_bus(1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check("reset_ack", d, 32'(ack[d]), 32'h0);
         check("reset_err", d, 32'(err[d]), 32'h0);
         check("reset_rty", d, 32'(rty[d]), 32'h0);
         check("reset_dat", d, dat_r[d], 32'h0);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Preload every word of the zero-wait instance with a linear burst.
      burst(0, 1'b1, 1'b0, 32'h0, int'(DEPTH), 2'b00, 32'h1000_0000, 1'b0, -1, -1);
      idle_bus(0);
      @(posedge clk);
      #1;

      // Byte-lane merge.
      classic(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
      classic(0, 1'b1, 32'h10, 32'h0000_0055, 4'h1);
      classic(0, 1'b0, 32'h10, 32'h0, 4'h0);
      classic(0, 1'b1, 32'h14, 32'h1234_5678, 4'h0);
      classic(0, 1'b0, 32'h14, 32'h0, 4'h0);

      // Wait-state instance: latency, then a strobe dropped mid-count.
      classic(1, 1'b1, 32'h0, 32'hCAFE_F00D, 4'hF);
      classic(1, 1'b0, 32'h0, 32'h0, 4'h0);
      cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 32'h0;
      @(posedge clk);
      @(posedge clk);
      #1;
      stb[1] = 1'b0;
      repeat (6) begin
         @(negedge clk);
         check("aborted_wait_no_term", 1, 32'(ack[1] | err[1]), 32'h0);
      end
      @(posedge clk);
      #1;
      idle_bus(1);
      classic(1, 1'b0, 32'h0, 32'h0, 4'h0);

      // Wrap-4 write burst from word 6; follow-up read must see an idle slave.
      burst(0, 1'b1, 1'b0, 32'h18, 4, 2'b01, 32'h1, 1'b0, -1, -1);
      classic(0, 1'b0, 32'h10, 32'h0, 4'h0);
      classic(0, 1'b0, 32'h14, 32'h0, 4'h0);
      classic(0, 1'b0, 32'h18, 32'h0, 4'h0);
      classic(0, 1'b0, 32'h1C, 32'h0, 4'h0);

      // Address errors.
      classic(0, 1'b0, 32'h400, 32'h0, 4'h0);
      classic(0, 1'b0, 32'h2, 32'h0, 4'h0);
      classic(0, 1'b1, 32'h401, 32'hFFFF_FFFF, 4'hF);
      classic(0, 1'b0, 32'h0, 32'h0, 4'h0);

      // Linear read burst running off the top, with a 2-cycle strobe gap.
      burst(0, 1'b0, 1'b0, 32'h3F8, 8, 2'b00, 32'h0, 1'b0, 1, -1);
      classic(0, 1'b0, 32'h3F8, 32'h0, 4'h0);

      // Reset pulsed on the third beat of a write burst.
      burst(0, 1'b1, 1'b0, 32'h40, 4, 2'b00, 32'hA0, 1'b0, -1, 2);
      classic(0, 1'b0, 32'h40, 32'h0, 4'h0);
      classic(0, 1'b0, 32'h44, 32'h0, 4'h0);
      classic(0, 1'b0, 32'h48, 32'h0, 4'h0);
      classic(0, 1'b0, 32'h4C, 32'h0, 4'h0);

      // Random traffic on the zero-wait instance.
      repeat (120) begin
         if ($urandom_range(0, 3) < 2) begin
            word = int'($urandom_range(0, DEPTH + 15));
            a = 32'(word) * 4;
            if ($urandom_range(0, 9) == 0) a = a | 32'($urandom_range(1, 3));
            classic(0, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
         end else begin
            word = int'($urandom_range(0, DEPTH - 1));
            nb = int'($urandom_range(1, 8));
            pk = (nb > 2 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, nb - 1)) : -1;
            burst(0, 1'b0, 1'b1, 32'(word) * 4, nb, 2'($urandom_range(0, 3)), 32'h0, 1'b1, pk, -1);
            idle_bus(0);
            @(posedge clk);
            #1;
         end
      end

      // Random traffic on the wait-state instance over a preloaded window.
      burst(1, 1'b1, 1'b0, 32'h0, 16, 2'b00, 32'h5000_0000, 1'b0, -1, -1);
      idle_bus(1);
      @(posedge clk);
      #1;
      repeat (25) begin
         if ($urandom_range(0, 4) == 0) word = int'($urandom_range(DEPTH, DEPTH + 7));
         else word = int'($urandom_range(0, 15));
         classic(1, 1'($urandom_range(0, 1)), 32'(word) * 4, $urandom, 4'($urandom_range(0, 15)));
      end
      burst(1, 1'b0, 1'b1, 32'h20, 6, 2'b10, 32'h0, 1'b1, 3, -1);
      idle_bus(1);

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("queue_drained", 0, 32'(q0.size()), 32'h0);
      check("queue_drained", 1, 32'(q1.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
